ethernet_tx_frame: RTL

- GMII transmit framer for one switch port; the transmit-side counterpart of the per-port receive framer.
- Takes a frame as a byte stream from the egress buffer using a valid/ready handshake with start-of-packet and end-of-packet markers.
- Emits the frame on GMII with preamble and SFD, zero padding up to the minimum frame size, the Ethernet CRC32 FCS, and the inter-frame gap.
- Sits between the egress queue and the PHY, in the same clock domain as the receive path.

---
 rtl/ethernet_tx_frame.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ethernet_tx_frame.sv
// GMII transmit framer: preamble/SFD insertion, zero padding, CRC32 FCS and
// inter-frame gap, with abort handling for source underrun and oversize frames.
module ethernet_tx_frame #(
    parameter int pIFG_BYTES = 12,
    parameter int pMIN_FRAME = 60,
    parameter int pMAX_FRAME = 1514
) (
    input  logic        iclk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    input  logic        i_sop,
    input  logic        i_eop,
    output logic        o_ready,
    output logic        o_tx_en,
    output logic        o_tx_er,
    output logic [7:0]  o_tx_d,
    output logic        o_busy,
    output logic [15:0] o_pkt_cnt,
    output logic        o_abort
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_PRE   = 4'd1,
        S_SFD   = 4'd2,
        S_DATA  = 4'd3,
        S_LAST  = 4'd4,
        S_PAD   = 4'd5,
        S_FCS   = 4'd6,
        S_ABORT = 4'd7,
        S_DROP  = 4'd8,
        S_IFG   = 4'd9
    } state_e;

    localparam logic [10:0] MIN_C = 11'(pMIN_FRAME);
    localparam logic [10:0] MAX_C = 11'(pMAX_FRAME);
    // The IDLE sampling cycle is itself idle on the wire, so IFG is one short.
    localparam logic [7:0]  IFG_LAST = (pIFG_BYTES > 1) ? 8'(pIFG_BYTES - 2) : 8'd0;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] dat);
        logic [31:0] c;
        c = crc ^ {24'h000000, dat};
        for (int b = 0; b < 8; b++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 32'hEDB88320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic        drop_q, drop_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic [7:0]  tx_d_q, tx_d_d;
    logic        busy_q, busy_d;
    logic        abort_q, abort_d;

    logic        ready_s;
    logic        accept_s;
    logic [31:0] fcs_s;
    logic [1:0]  fcs_idx_s;

    assign ready_s   = (state_q == S_SFD) || (state_q == S_DATA) || (state_q == S_DROP);
    assign accept_s  = ready_s & i_valid;
    assign fcs_s     = ~crc_q;
    assign fcs_idx_s = (state_q == S_FCS) ? (cnt_q[1:0] + 2'd1) : 2'd0;

    assign o_ready   = ready_s;
    assign o_tx_en   = tx_en_q;
    assign o_tx_er   = tx_er_q;
    assign o_tx_d    = tx_d_q;
    assign o_busy    = busy_q;
    assign o_pkt_cnt = pkt_cnt_q;
    assign o_abort   = abort_q;

    // State register.
    always_ff @(posedge iclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid && i_sop) begin
                    state_d = S_PRE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                if (cnt_q == 8'd6) begin
                    state_d = S_SFD;
                end else begin
                    state_d = S_PRE;
                end
            end
            S_SFD, S_DATA: begin
                if (!i_valid) begin
                    state_d = S_ABORT;
                end else if (byte_cnt_q == MAX_C) begin
                    state_d = S_ABORT;
                end else if (i_eop) begin
                    state_d = S_LAST;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_LAST, S_PAD: begin
                if (byte_cnt_q < MIN_C) begin
                    state_d = S_PAD;
                end else begin
                    state_d = S_FCS;
                end
            end
            S_FCS: begin
                if (cnt_q == 8'd3) begin
                    state_d = S_IFG;
                end else begin
                    state_d = S_FCS;
                end
            end
            S_ABORT: begin
                if (drop_q) begin
                    state_d = S_DROP;
                end else begin
                    state_d = S_IFG;
                end
            end
            S_DROP: begin
                if (accept_s && i_eop) begin
                    state_d = S_IFG;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_IFG: begin
                if (cnt_q >= IFG_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_IFG;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; GMII outputs follow the upcoming state.
    always_comb begin
        tx_en_d    = 1'b0;
        tx_er_d    = 1'b0;
        tx_d_d     = 8'h00;
        abort_d    = 1'b0;
        busy_d     = (state_d != S_IDLE);
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        drop_d     = drop_q;
        pkt_cnt_d  = pkt_cnt_q;

        if (state_d == state_q) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd0;
        end

        case (state_d)
            S_PRE: begin
                tx_en_d = 1'b1;
                tx_d_d  = 8'h55;
            end
            S_SFD: begin
                tx_en_d = 1'b1;
                tx_d_d  = 8'hD5;
            end
            S_DATA, S_LAST: begin
                tx_en_d = 1'b1;
                tx_d_d  = i_data;
            end
            S_PAD: begin
                tx_en_d = 1'b1;
                tx_d_d  = 8'h00;
            end
            S_FCS: begin
                tx_en_d = 1'b1;
                tx_d_d  = fcs_s[{fcs_idx_s, 3'b000} +: 8];
            end
            S_ABORT: begin
                tx_en_d = 1'b1;
                tx_er_d = 1'b1;
                abort_d = (state_q != S_ABORT);
            end
            default: begin
                tx_en_d = 1'b0;
            end
        endcase

        case (state_q)
            S_IDLE: begin
                byte_cnt_d = 11'd0;
                crc_d      = 32'hFFFFFFFF;
                drop_d     = 1'b0;
            end
            S_SFD, S_DATA: begin
                if (accept_s) begin
                    byte_cnt_d = byte_cnt_q + 11'd1;
                    crc_d      = crc32_byte(crc_q, i_data);
                end else begin
                    byte_cnt_d = byte_cnt_q;
                end
            end
            default: begin
                byte_cnt_d = byte_cnt_q;
            end
        endcase

        if (state_d == S_PAD) begin
            byte_cnt_d = byte_cnt_q + 11'd1;
            crc_d      = crc32_byte(crc_q, 8'h00);
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end

        // An eop byte that triggers the abort leaves nothing to drop.
        if ((state_d == S_ABORT) && (state_q != S_ABORT)) begin
            drop_d = !(accept_s && i_eop);
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end

        if ((state_q == S_FCS) && (state_d == S_IFG)) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge iclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q      <= 8'd0;
            byte_cnt_q <= 11'd0;
            crc_q      <= 32'hFFFFFFFF;
            drop_q     <= 1'b0;
            pkt_cnt_q  <= 16'd0;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            tx_d_q     <= 8'h00;
            busy_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            drop_q     <= drop_d;
            pkt_cnt_q  <= pkt_cnt_d;
            tx_en_q    <= tx_en_d;
            tx_er_q    <= tx_er_d;
            tx_d_q     <= tx_d_d;
            busy_q     <= busy_d;
            abort_q    <= abort_d;
        end
    end

endmodule
